// File: rtl/hdmi_video_pkg.sv
// Shared video definitions for the HDMI pattern source: raster defaults,
// axis arithmetic and the 32-bit pixel packing used by encoder and logger.
package hdmi_video_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int V_ACTIVE_DEF = 300;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

  // Pad byte on top keeps the word layout identical for encoder and PPM logger.
  function automatic logic [31:0] pack_rgb(input rgb_t px);
    return {8'h00, px};
  endfunction

endpackage

// File: rtl/hdmi_pattern_src_if.sv
// Upstream pixel stream (valid/ready with start-of-frame marker) feeding
// the HDMI pattern source.
interface hdmi_pattern_src_if;
  logic        pix_valid;
  logic        pix_sof;
  logic [23:0] pix_data;
  logic        pix_ready;

  modport master (output pix_valid, output pix_sof, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_sof, input pix_data, output pix_ready);
endinterface

// File: rtl/hdmi_pattern_src_timing_cnt.sv
// Raster position counters with frame-boundary run control; decodes the
// active/sync regions for the current position.
module video_timing_cnt
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic active,
  output logic hs_act,
  output logic vs_act,
  output logic origin,
  output logic frame_end
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN0  = HW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [HW-1:0] H_SYN1  = HW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYN0  = VW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [VW-1:0] V_SYN1  = VW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          running_q, running_d;

  // NOTE: every variable assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    running_d = running_q;
    if (!running_q) begin
      running_d = en;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d   = '0;
        running_d = en;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      running_q <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      running_q <= running_d;
    end
  end

  assign active    = running_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_act    = running_q && (h_cnt_q >= H_SYN0) && (h_cnt_q < H_SYN1);
  assign vs_act    = running_q && (v_cnt_q >= V_SYN0) && (v_cnt_q < V_SYN1);
  assign origin    = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_end = running_q && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: rtl/hdmi_pattern_src.sv
// HDMI video source: raster timing plus a pixel-stream consumer, with
// underflow fill, start-of-frame alignment checking and a frame counter.
module hdmi_pattern_src
  import hdmi_video_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          H_FP     = H_FP_DEF,
  parameter int          H_SYNC   = H_SYNC_DEF,
  parameter int          H_BP     = H_BP_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter int          V_FP     = V_FP_DEF,
  parameter int          V_SYNC   = V_SYNC_DEF,
  parameter int          V_BP     = V_BP_DEF,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [23:0] FILL_RGB = 24'hFF00FF
) (
  input  logic                hdmi_clk,
  input  logic                rst_n,
  input  logic                en,
  hdmi_pattern_src_if.slave   pix,
  output logic                hdmi_vs,
  output logic                hdmi_hs,
  output logic                hdmi_de,
  output logic [31:0]         hdmi_data,
  output logic                underflow,
  output logic                sync_err,
  output logic [7:0]          frame_cnt
);

  logic active, hs_act, vs_act, origin, frame_end;

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk       (hdmi_clk),
    .rst_n     (rst_n),
    .en        (en),
    .active    (active),
    .hs_act    (hs_act),
    .vs_act    (vs_act),
    .origin    (origin),
    .frame_end (frame_end)
  );

  // The raster never stalls: every active cycle consumes a pixel if one is offered.
  assign pix.pix_ready = active;

  logic        vs_q, vs_d, hs_q, hs_d, de_q, de_d;
  logic [31:0] data_q, data_d;
  logic        underflow_q, underflow_d, sync_err_q, sync_err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        starve, sof_bad;

  always_comb begin
    starve      = active && !pix.pix_valid;
    sof_bad     = active && pix.pix_valid && (origin ? !pix.pix_sof : pix.pix_sof);
    de_d        = active;
    hs_d        = hs_act ? SYNC_POL : ~SYNC_POL;
    vs_d        = vs_act ? SYNC_POL : ~SYNC_POL;
    data_d      = '0;
    if (active) data_d = pack_rgb(rgb_t'(pix.pix_valid ? pix.pix_data : FILL_RGB));
    // Clearing at the frame origin loses to an underflow on that same pixel.
    underflow_d = (origin ? 1'b0 : underflow_q) | starve;
    sync_err_d  = sync_err_q | sof_bad;
    frame_cnt_d = frame_cnt_q;
    if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= ~SYNC_POL;
      hs_q        <= ~SYNC_POL;
      de_q        <= 1'b0;
      data_q      <= '0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vs_q        <= vs_d;
      hs_q        <= hs_d;
      de_q        <= de_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hdmi_vs   = vs_q;
  assign hdmi_hs   = hs_q;
  assign hdmi_de   = de_q;
  assign hdmi_data = data_q;
  assign underflow = underflow_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_pattern_src.sv
// Self-checking bench for hdmi_pattern_src on a 14x7 raster: directed phases
// with randomized pixel data against a linear-position frame model.
module tb_hdmi_pattern_src;

  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        hdmi_vs, hdmi_hs, hdmi_de, underflow, sync_err;
  logic [31:0] hdmi_data;
  logic [7:0]  frame_cnt;

  hdmi_pattern_src_if pix_if ();

  hdmi_pattern_src #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .SYNC_POL (1'b0), .FILL_RGB (24'hFF00FF)
  ) dut (
    .hdmi_clk  (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pix       (pix_if.slave),
    .hdmi_vs   (hdmi_vs),
    .hdmi_hs   (hdmi_hs),
    .hdmi_de   (hdmi_de),
    .hdmi_data (hdmi_data),
    .underflow (underflow),
    .sync_err  (sync_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame model: position is a linear index into the 98-clock frame.
  bit          m_run;
  int          m_p;
  logic        e_de, e_hs, e_vs, e_uf, e_se;
  logic [31:0] e_data;
  logic [7:0]  e_fc;
  int          de_seen, hs_low, vs_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_run = 1'b0; m_p = 0;
    e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_uf = 1'b0; e_se = 1'b0;
    e_data = '0; e_fc = '0;
  endtask

  task automatic model_update();
    int  h, v;
    bit  act;
    h   = m_p % HT;
    v   = m_p / HT;
    act = m_run && (h < HA) && (v < VA);
    e_de   = act;
    e_hs   = !(m_run && (h >= HA + HFP) && (h < HA + HFP + HSY));
    e_vs   = !(m_run && (v >= VA + VFP) && (v < VA + VFP + VSY));
    e_data = !act ? 32'h0 : (pix_if.pix_valid ? {8'h00, pix_if.pix_data} : 32'h00FF00FF);
    e_uf   = ((m_p == 0) ? 1'b0 : e_uf) | (act && !pix_if.pix_valid);
    e_se   = e_se | (act && pix_if.pix_valid && ((m_p == 0) != pix_if.pix_sof));
    if (m_run) begin
      if (m_p == FT - 1) begin
        e_fc  = e_fc + 8'd1;
        m_run = en;
        m_p   = 0;
      end else begin
        m_p++;
      end
    end else begin
      m_run = en;
    end
  endtask

  task automatic check_all();
    bit exp_rdy;
    exp_rdy = m_run && ((m_p % HT) < HA) && ((m_p / HT) < VA);
    check("de", 32'(hdmi_de), 32'(e_de));
    check("hs", 32'(hdmi_hs), 32'(e_hs));
    check("vs", 32'(hdmi_vs), 32'(e_vs));
    check("data", hdmi_data, e_data);
    check("pix_ready", 32'(pix_if.pix_ready), 32'(exp_rdy));
    check("underflow", 32'(underflow), 32'(e_uf));
    check("sync_err", 32'(sync_err), 32'(e_se));
    check("frame_cnt", 32'(frame_cnt), 32'(e_fc));
    if (hdmi_de) de_seen++;
    if (!hdmi_hs) hs_low++;
    if (!hdmi_vs) vs_low++;
  endtask

  // One clock: inputs already set; model follows the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  // Presents the next pixel; sof_pos selects which frame position carries the marker.
  task automatic drive(input bit valid, input int sof_pos);
    pix_if.pix_valid = valid;
    pix_if.pix_data  = 24'($urandom);
    pix_if.pix_sof   = m_run && (m_p == sof_pos);
  endtask

  initial begin
    int fc_before;
    rst_n = 1'b0; en = 1'b0;
    pix_if.pix_valid = 1'b0; pix_if.pix_sof = 1'b0; pix_if.pix_data = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Idle with en low: reset levels held.
    for (int i = 0; i < 200; i++) begin drive(1'b1, 0); step(); end

    // Always-valid source, first frame, then per-frame statistics.
    de_seen = 0; hs_low = 0; vs_low = 0;
    en = 1'b1;
    for (int i = 0; i < FT + 1; i++) begin drive(1'b1, 0); step(); end
    check("de_per_frame", 32'(de_seen), 32'(HA * VA));
    check("hs_low_per_frame", 32'(hs_low), 32'(HSY * VT));
    check("vs_low_per_frame", 32'(vs_low), 32'(HT * VSY));
    check("frame_cnt_first", 32'(frame_cnt), 32'd1);
    for (int i = 0; i < FT; i++) begin drive(1'b1, 0); step(); end

    // Starve pixel (2,1) once.
    for (int i = 0; i < FT; i++) begin
      drive(!(m_run && m_p == HT + 2), 0);
      step();
    end
    for (int i = 0; i < FT; i++) begin drive(1'b1, 0); step(); end

    // Start-of-frame marker on pixel (3,0) for one frame; flag must persist.
    for (int i = 0; i < FT; i++) begin drive(1'b1, 3); step(); end
    for (int i = 0; i < 3 * FT; i++) begin drive(1'b1, 0); step(); end
    check("sync_err_sticky", 32'(sync_err), 32'd1);

    // Randomized valid drops and run-enable toggling.
    for (int i = 0; i < 8 * FT; i++) begin
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 49) == 0) ? 5 : 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      step();
    end

    // Drop en mid-frame: the frame completes and frame_cnt steps once.
    en = 1'b1;
    for (int i = 0; i < 2 * FT + 2; i++) begin drive(1'b1, 0); step(); end
    while (!(m_run && m_p == 40)) begin drive(1'b1, 0); step(); end
    fc_before = int'(frame_cnt);
    en = 1'b0;
    for (int i = 0; i < 200; i++) begin drive(1'b1, 0); step(); end
    check("frame_cnt_after_stop", 32'(frame_cnt), 32'((fc_before + 1) % 256));
    check("de_after_stop", 32'(hdmi_de), 32'd0);

    // Async reset in the middle of an active line.
    en = 1'b1;
    for (int i = 0; i < 2 * HT + 4; i++) begin drive(1'b1, 0); step(); end
    #2;
    rst_n = 1'b0; en = 1'b0;
    reset_model();
    #1;
    check("rst_de", 32'(hdmi_de), 32'd0);
    check("rst_data", hdmi_data, 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin drive(1'b1, 0); step(); end
    en = 1'b1;
    for (int i = 0; i < 2 * FT + 1; i++) begin drive(1'b1, 0); step(); end
    check("frame_cnt_after_rst", 32'(frame_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
